// File: rtl/bus_arbiter5.sv
// bus_arbiter5: five-way round-robin arbiter driving a shared datapath mux select.
// Optional burst limit: define ARB_BURST_LIMIT_EN to force rotation after MAX_BURST cycles.
module bus_arbiter5 #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    output logic [4:0] gnt,
    output logic [2:0] sel,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_n;
    logic [4:0] gnt_n, cand;
    logic [2:0] sel_n, last, last_n, win, p;
    logic       hit, own, force_rot;
`ifdef ARB_BURST_LIMIT_EN
    logic [CW-1:0] cnt, cnt_n;
`endif

    if (MAX_BURST < 1 || 2**CW < MAX_BURST) begin : g_bad_cfg
        $error("bus_arbiter5: need MAX_BURST >= 1 and 2**CW >= MAX_BURST");
    end

    assign busy = (state == GRANT);
    assign own  = |(req & gnt);

    // Round-robin scan starting after the last owner; while granted, the owner is masked out
    always_comb begin
        cand = (state == IDLE) ? req : (req & ~gnt);
        hit  = 1'b0;
        win  = last;
        p    = '0;
        for (int k = 5; k >= 1; k--) begin
            p = 3'((int'(last) + k) % 5);
            if (cand[p]) begin
                hit = 1'b1;
                win = p;
            end
        end
    end

    // Next-state logic: grant, hold, hand off without a bubble, or drop to idle
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        last_n  = last;
`ifdef ARB_BURST_LIMIT_EN
        cnt_n     = cnt;
        force_rot = (cnt == CW'(MAX_BURST - 1)) && hit;
`else
        force_rot = 1'b0;
`endif
        if (state == GRANT && own && !force_rot) begin
`ifdef ARB_BURST_LIMIT_EN
            cnt_n = (cnt == CW'(MAX_BURST - 1)) ? '0 : (cnt == '1) ? cnt : cnt + 1'b1;
`endif
        end else if (hit) begin
            state_n = GRANT;
            gnt_n   = 5'(1) << win;
            sel_n   = win;
            last_n  = win;
`ifdef ARB_BURST_LIMIT_EN
            cnt_n   = '0;
`endif
        end else begin
            state_n = IDLE;
            gnt_n   = '0;
        end
    end

    // State register; reset points last at source 4 so source 0 wins first
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= 3'd4;
`ifdef ARB_BURST_LIMIT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            last  <= last_n;
`ifdef ARB_BURST_LIMIT_EN
            cnt   <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_bus_arbiter5.sv
// tb_bus_arbiter5: directed-vector bench for bus_arbiter5 (either ARB_BURST_LIMIT_EN build).
module tb_bus_arbiter5;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    bus_arbiter5 #(.MAX_BURST(4), .CW(3)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("sel_range", 32'(sel <= 3'd4), 1);
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    endtask

    task automatic expect_state(input string tag, input logic [4:0] g, input logic [2:0] s, input logic b);
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_sel"}, 32'(sel), 32'(s));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        // 1: reset beats requests, then source 0 wins first
        reset = 1'b1; req = 5'b11111;
        step(); step();
        expect_state("t1_rst", 5'b00000, 3'd0, 1'b0);
        reset = 1'b0;
        step();
        expect_state("t1_first", 5'b00001, 3'd0, 1'b1);
        req = '0;
        step();
        expect_state("t1_idle", 5'b00000, 3'd0, 1'b0);

        // 2: from last=4, pick source 2, then bubble-free handoff to 4
        reset = 1'b1; step(); reset = 1'b0;
        req = 5'b10100;
        step();
        expect_state("t2_grant2", 5'b00100, 3'd2, 1'b1);
        req = 5'b10000;
        step();
        expect_state("t2_hand4", 5'b10000, 3'd4, 1'b1);
        req = '0;
        step();
        expect_state("t2_idle", 5'b00000, 3'd4, 1'b0);

        // 3: all requesting, each owner drops for one cycle -> 0,1,2,3,4,0
        req = 5'b11111;
        step();
        expect_state("t3_o0", 5'b00001, 3'd0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            req = 5'b11111 & ~(5'(1) << ((i - 1) % 5));
            step();
            expect_state($sformatf("t3_o%0d", i), 5'(1) << (i % 5), 3'(i % 5), 1'b1);
        end
        req = '0;
        step();
        expect_state("t3_idle", 5'b00000, 3'd0, 1'b0);

        // 4: two sources held; burst limit alternates every 4 cycles, otherwise source 0 keeps it
        reset = 1'b1; step(); reset = 1'b0;
        req = 5'b00011;
        for (int c = 0; c < 12; c++) begin
            step();
`ifdef ARB_BURST_LIMIT_EN
            chk($sformatf("t4_c%0d", c), 32'(gnt), ((c / 4) % 2) ? 32'h2 : 32'h1);
`else
            chk($sformatf("t4_c%0d", c), 32'(gnt), 32'h1);
`endif
        end
        req = '0;
        step();
        expect_state("t4_idle", 5'b00000, 3'd0, 1'b0);

        // 5: lone requester keeps the grant continuously; sel holds after release
        req = 5'b01000;
        for (int c = 0; c < 10; c++) begin
            step();
            expect_state($sformatf("t5_c%0d", c), 5'b01000, 3'd3, 1'b1);
        end
        req = '0;
        step();
        expect_state("t5_idle", 5'b00000, 3'd3, 1'b0);

        // 6: reset mid-burst clears everything; source 0 wins afterwards
        req = 5'b01000;
        step(); step();
        expect_state("t6_burst", 5'b01000, 3'd3, 1'b1);
        reset = 1'b1;
        step();
        expect_state("t6_rst", 5'b00000, 3'd0, 1'b0);
        reset = 1'b0; req = 5'b01001;
        step();
        expect_state("t6_after", 5'b00001, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
